axi4_lite_initiator: RTL and testbench

//  Bridges the core's native memory port (valid/ready, one outstanding access) to an AXI4-lite initiator.

---
 rtl/axi4_lite_initiator_pkg.sv | 16 +
 rtl/axi4_lite_initiator_if.sv | 36 +++
 rtl/axi4_lite_initiator_watchdog.sv | 37 +++
 rtl/axi4_lite_initiator.sv | 212 +++++++++++++++++++++
 tb/tb_axi4_lite_initiator.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_initiator_pkg.sv
// Shared types and constants for the native-port to AXI4-lite initiator bridge.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP
    } state_e;

    localparam logic [2:0]  PROT_DATA     = 3'b000;
    localparam logic [2:0]  PROT_INSN     = 3'b100;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi4_lite_initiator_if.sv
// AXI4-lite bus bundle (no resp channels); master = initiator side, slave = responder side.
interface axi4_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );

endinterface

// File: rtl/axi4_lite_initiator_watchdog.sv
// Access watchdog: counts busy cycles and flags expiry at LIMIT-1.
// Exists only when AXI_TIMEOUT_EN is defined.
`ifdef AXI_TIMEOUT_EN
module axi_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic busy_i,
    output logic expired_o
);
    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = busy_i && (cnt_q == CNT_W'(LIMIT - 1));

    // Held at zero while idle, so every new access starts from a clean count.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/axi4_lite_initiator.sv
// Native valid/ready memory port to single-beat AXI4-lite initiator, one access in flight.
// Optional watchdog abort enabled by defining AXI_TIMEOUT_EN.
module axi4_lite_initiator
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef AXI_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid_i,
    input  logic                mem_instr_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    output logic                mem_ready_o,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_err_o,
    axi4_lite_if.master         m_axi
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [2:0]          prot_q, prot_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                mem_ready_q, mem_ready_d;
    logic                mem_err_q, mem_err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                aw_fire, w_fire;
    logic                wd_expired;

    assign aw_fire = awvalid_q && m_axi.awready;
    assign w_fire  = wvalid_q && m_axi.wready;

`ifdef AXI_TIMEOUT_EN
    axi_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .resetn    (resetn),
        .busy_i    (state_q != IDLE),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // NOTE: every variable gets its hold value before the case; a missed branch would infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        rdata_d     = rdata_q;

        unique case (state_q)
            IDLE: begin
                // The completion pulse blocks re-acceptance of a still-high mem_valid.
                if (mem_valid_i && !mem_ready_q) begin
                    addr_d    = mem_addr_i;
                    wdata_d   = mem_wdata_i;
                    wstrb_d   = mem_wstrb_i;
                    prot_d    = mem_instr_i ? PROT_INSN : PROT_DATA;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (mem_wstrb_i == '0) begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi.rvalid && rready_q) begin
                    rdata_d     = m_axi.rdata;
                    mem_ready_d = 1'b1;
                    rready_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            WR: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid && bready_q) begin
                    mem_ready_d = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AXI_TIMEOUT_EN
        // Abort overrides any handshake landing in the same cycle.
        if (wd_expired) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            mem_ready_d = 1'b1;
            mem_err_d   = 1'b1;
            state_d     = IDLE;
            if ((state_q == RD_ADDR) || (state_q == RD_DATA)) begin
                rdata_d = DATA_W'(TIMEOUT_RDATA);
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= PROT_DATA;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = PROT_DATA;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = prot_q;
    assign m_axi.rready  = rready_q;

    assign mem_ready_o = mem_ready_q;
    assign mem_rdata_o = rdata_q;
`ifdef AXI_TIMEOUT_EN
    assign mem_err_o   = mem_err_q;
`else
    assign mem_err_o   = 1'b0 & mem_err_q;
`endif

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// Directed bench for axi4_lite_initiator: bench plays core and AXI responder cycle by cycle.
// The timeout scenario runs when AXI_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_axi4_lite_initiator;
    import axi4_lite_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_instr, mem_ready, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    int          total = 0;
    int          bad = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;

    axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi4_lite_initiator #(
        .ADDR_W (32),
        .DATA_W (32)
`ifdef AXI_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_valid_i (mem_valid),
        .mem_instr_i (mem_instr),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_ready_o (mem_ready),
        .mem_rdata_o (mem_rdata),
        .mem_err_o   (mem_err),
        .m_axi       (axi)
    );

    always #5 clk = ~clk;

    // Handshake tally, used to detect duplicate or missing beats.
    always @(posedge clk) begin
        if (axi.arvalid && axi.arready) ar_cnt++;
        if (axi.awvalid && axi.awready) aw_cnt++;
        if (axi.wvalid && axi.wready)   w_cnt++;
        if (axi.bvalid && axi.bready)   b_cnt++;
        if (axi.rvalid && axi.rready)   r_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed=hang expected=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int ar0, aw0, w0, b0, r0;

        resetn      = 1'b0;
        mem_valid   = 1'b0;
        mem_instr   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        repeat (3) step();

        // Reset state
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        resetn = 1'b1;
        step();

        // 1: instruction read, zero-wait responder
        axi.arready = 1'b1;
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'h0;
        step();
        check("t1_arvalid", axi.arvalid, 1);
        check("t1_araddr", axi.araddr, 32'h0000_0100);
        check("t1_arprot", axi.arprot, 3'b100);
        check("t1_no_early_ready", mem_ready, 0);
        step();
        check("t1_arvalid_drop", axi.arvalid, 0);
        check("t1_rready", axi.rready, 1);
        axi.rvalid = 1'b1; axi.rdata = 32'h1234_5678;
        step();
        check("t1_mem_ready", mem_ready, 1);
        check("t1_mem_rdata", mem_rdata, 32'h1234_5678);
        check("t1_rready_drop", axi.rready, 0);
        mem_valid = 1'b0; axi.rvalid = 1'b0; axi.arready = 1'b0;
        step();
        check("t1_ready_pulse", mem_ready, 0);

        // 2: write, AW accepted three cycles before W
        ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_0200;
        mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'b0011;
        step();
        check("t2_awvalid", axi.awvalid, 1);
        check("t2_wvalid", axi.wvalid, 1);
        check("t2_awaddr", axi.awaddr, 32'h0000_0200);
        check("t2_awprot", axi.awprot, 3'b000);
        check("t2_wdata", axi.wdata, 32'hCAFE_F00D);
        check("t2_wstrb", axi.wstrb, 4'b0011);
        axi.awready = 1'b1;
        step();
        axi.awready = 1'b0;
        check("t2_awvalid_drop", axi.awvalid, 0);
        check("t2_wvalid_held", axi.wvalid, 1);
        check("t2_bready_early", axi.bready, 0);
        step();
        check("t2_wvalid_held2", axi.wvalid, 1);
        step();
        axi.wready = 1'b1;
        check("t2_bready_wait", axi.bready, 0);
        step();
        axi.wready = 1'b0;
        check("t2_wvalid_drop", axi.wvalid, 0);
        check("t2_bready", axi.bready, 1);
        check("t2_no_early_ready", mem_ready, 0);
        axi.bvalid = 1'b1;
        step();
        check("t2_mem_ready", mem_ready, 1);
        check("t2_bready_drop", axi.bready, 0);
        mem_valid = 1'b0; axi.bvalid = 1'b0;
        step();
        check("t2_ready_pulse", mem_ready, 0);
        check("t2_aw_beats", aw_cnt - aw0, 1);
        check("t2_w_beats", w_cnt - w0, 1);
        check("t2_b_beats", b_cnt - b0, 1);
        check("t2_ar_beats", ar_cnt - ar0, 0);

        // 3: AW and W together, bvalid held off for 5 cycles
        aw0 = aw_cnt; w0 = w_cnt;
        axi.awready = 1'b1; axi.wready = 1'b1;
        mem_valid = 1'b1; mem_addr = 32'h0000_0300; mem_wdata = 32'h1122_3344; mem_wstrb = 4'hF;
        step();
        check("t3_valids", {axi.awvalid, axi.wvalid}, 2'b11);
        step();
        axi.awready = 1'b0; axi.wready = 1'b0;
        check("t3_valids_drop", {axi.awvalid, axi.wvalid}, 2'b00);
        for (int i = 0; i < 5; i++) begin
            check("t3_wait_bready", axi.bready, 1);
            check("t3_wait_ready", mem_ready, 0);
            step();
        end
        axi.bvalid = 1'b1;
        check("t3_hs_cycle_ready", mem_ready, 0);
        step();
        check("t3_mem_ready", mem_ready, 1);
        mem_valid = 1'b0; axi.bvalid = 1'b0;
        step();
        check("t3_aw_beats", aw_cnt - aw0, 1);
        check("t3_w_beats", w_cnt - w0, 1);

        // 4: back-to-back read then write, mem_valid held across the completion
        ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt; r0 = r_cnt;
        axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        mem_valid = 1'b1; mem_addr = 32'h0000_0400; mem_wstrb = 4'h0;
        step();
        step();
        axi.rvalid = 1'b1; axi.rdata = 32'hA5A5_0001;
        step();
        check("t4_rd_ready", mem_ready, 1);
        check("t4_rd_data", mem_rdata, 32'hA5A5_0001);
        axi.rvalid = 1'b0;
        mem_addr = 32'h0000_0404; mem_wdata = 32'h0BAD_CAFE; mem_wstrb = 4'hF;
        step();
        check("t4_gap_ready", mem_ready, 0);
        check("t4_gap_no_aw", axi.awvalid, 0);
        check("t4_gap_no_ar", axi.arvalid, 0);
        step();
        check("t4_wr_issue", {axi.awvalid, axi.wvalid}, 2'b11);
        check("t4_wr_addr", axi.awaddr, 32'h0000_0404);
        step();
        axi.bvalid = 1'b1;
        step();
        check("t4_wr_ready", mem_ready, 1);
        mem_valid = 1'b0; axi.bvalid = 1'b0;
        step();
        check("t4_ar_beats", ar_cnt - ar0, 1);
        check("t4_r_beats", r_cnt - r0, 1);
        check("t4_aw_beats", aw_cnt - aw0, 1);
        check("t4_w_beats", w_cnt - w0, 1);
        axi.awready = 1'b0; axi.wready = 1'b0;

        // 5: reset while waiting for read data
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_0500; mem_wstrb = 4'h0;
        step();
        step();
        check("t5_rready", axi.rready, 1);
        resetn = 1'b0; mem_valid = 1'b0;
        step();
        check("t5_rst_arvalid", axi.arvalid, 0);
        check("t5_rst_rready", axi.rready, 0);
        check("t5_rst_ready", mem_ready, 0);
        check("t5_rst_state", dut.state_q, IDLE);
        resetn = 1'b1;
        step();
        r0 = r_cnt;
        mem_valid = 1'b1; mem_addr = 32'h0000_0504;
        step();
        check("t5_arprot_data", axi.arprot, 3'b000);
        step();
        axi.rvalid = 1'b1; axi.rdata = 32'h5555_AAAA;
        step();
        check("t5_mem_ready", mem_ready, 1);
        check("t5_mem_rdata", mem_rdata, 32'h5555_AAAA);
        mem_valid = 1'b0; axi.rvalid = 1'b0; axi.arready = 1'b0;
        step();
        check("t5_r_beats", r_cnt - r0, 1);

`ifdef AXI_TIMEOUT_EN
        // 6: arready never comes, watchdog aborts
        mem_valid = 1'b1; mem_addr = 32'h0000_0600; mem_wstrb = 4'h0;
        step();
        check("t6_arvalid", axi.arvalid, 1);
        for (int i = 1; i < 16; i++) begin
            step();
            check("t6_wait_ready", mem_ready, 0);
        end
        step();
        check("t6_mem_ready", mem_ready, 1);
        check("t6_mem_err", mem_err, 1);
        check("t6_rdata", mem_rdata, 32'hDEAD_BEEF);
        check("t6_arvalid_low", axi.arvalid, 0);
        mem_valid = 1'b0;
        step();
        check("t6_err_pulse", mem_err, 0);
        check("t6_ready_pulse", mem_ready, 0);
`else
        // 6: without the watchdog a stalled read just waits
        mem_valid = 1'b1; mem_addr = 32'h0000_0600; mem_wstrb = 4'h0;
        repeat (40) step();
        check("t6_stall_arvalid", axi.arvalid, 1);
        check("t6_stall_ready", mem_ready, 0);
        check("t6_stall_err", mem_err, 0);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'h0F0F_F0F0;
        step();
        check("t6_late_ready", mem_ready, 1);
        check("t6_late_rdata", mem_rdata, 32'h0F0F_F0F0);
        check("t6_late_err", mem_err, 0);
        mem_valid = 1'b0; axi.rvalid = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
